// File: rtl/instr_encoder_loader.sv
// Instruction encoder / loader.
// Packs host-supplied instruction fields into the 16-bit instruction word,
// range-checks immediates, and writes each accepted word sequentially into
// instruction memory starting at BASE_ADDR.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   start, finish        session open (resets address/counters) / close pulses
//   in_valid, in_ready   field bundle handshake
//   fmt, opcode, alu_op, rn, rd, rm, shift_op, imm   instruction fields
//   mem_write, mem_addr, mem_wdata, mem_ready        memory write port
//   busy, full, err, err_cnt, word_cnt, done         status
//
// state  | meaning
// IDLE   | no session; bundles ignored
// ACCEPT | session open, waiting for a field bundle
// WRITE  | encoded word presented to memory until mem_ready
// FULL   | last address written; waiting for finish or start
module instr_encoder_loader #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        fmt,
   input  logic [2:0]        opcode,
   input  logic [1:0]        alu_op,
   input  logic [2:0]        rn,
   input  logic [2:0]        rd,
   input  logic [2:0]        rm,
   input  logic [1:0]        shift_op,
   input  logic [15:0]       imm,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              full,
   output logic              err,
   output logic [7:0]        err_cnt,
   output logic [ADDR_W:0]   word_cnt,
   output logic              done
);

   localparam int CNT_W = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST_ADR = {ADDR_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCEPT = 2'd1,
      WRITE  = 2'd2,
      FULL   = 2'd3
   } state_t;

   state_t state;

   logic [15:0] enc_word;
   logic        imm_ok;
   logic        accept;

   // Signed range check: the bits above the kept field must all equal its sign bit.
   always_comb begin
      enc_word = {opcode, alu_op, 11'd0};
      imm_ok   = 1'b1;
      case (fmt)
         2'b00: enc_word[10:0] = {rn, rd, shift_op, rm};
         2'b01: begin
            enc_word[10:0] = {rn, imm[7:0]};
            imm_ok = (imm[15:7] == '0) || (imm[15:7] == '1);
         end
         2'b10: begin
            enc_word[10:0] = {rn, rd, imm[4:0]};
            imm_ok = (imm[15:4] == '0) || (imm[15:4] == '1);
         end
         default: enc_word[10:0] = 11'd0;
      endcase
   end

   assign accept    = (state == ACCEPT) && in_valid;
   assign in_ready  = (state == ACCEPT);
   assign mem_write = (state == WRITE);
   assign full      = (state == FULL);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mem_addr  <= BASE;
         mem_wdata <= 16'd0;
         err       <= 1'b0;
         err_cnt   <= 8'd0;
         word_cnt  <= '0;
         done      <= 1'b0;
      end else begin
         err  <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= ACCEPT;
                  mem_addr <= BASE;
                  word_cnt <= '0;
                  err_cnt  <= 8'd0;
               end
            end
            ACCEPT: begin
               // start restarts the session and takes precedence over a bundle;
               // a bundle in turn takes precedence over finish.
               if (start) begin
                  mem_addr <= BASE;
                  word_cnt <= '0;
                  err_cnt  <= 8'd0;
               end else if (accept) begin
                  if (imm_ok) begin
                     mem_wdata <= enc_word;
                     state     <= WRITE;
                  end else begin
                     err <= 1'b1;
                     if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                  end
               end else if (finish) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            WRITE: begin
               if (mem_ready) begin
                  word_cnt <= word_cnt + CNT_W'(1);
                  if (mem_addr == LAST_ADR) begin
                     state <= FULL;
                  end else begin
                     mem_addr <= mem_addr + ADDR_W'(1);
                     state    <= ACCEPT;
                  end
               end
            end
            FULL: begin
               if (start) begin
                  state    <= ACCEPT;
                  mem_addr <= BASE;
                  word_cnt <= '0;
                  err_cnt  <= 8'd0;
               end else if (finish) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, finish, in_valid, mem_ready;
   logic [1:0]  fmt, alu_op, shift_op;
   logic [2:0]  opcode, rn, rd, rm;
   logic [15:0] imm;

   // default-size instance
   logic        in_ready, mem_write, busy, full, err, done;
   logic [7:0]  mem_addr, err_cnt;
   logic [15:0] mem_wdata;
   logic [8:0]  word_cnt;

   // small instance (ADDR_W=3, BASE_ADDR=6) for the full-address-space case
   logic        s_in_ready, s_mem_write, s_busy, s_full, s_err, s_done;
   logic [2:0]  s_mem_addr;
   logic [7:0]  s_err_cnt;
   logic [15:0] s_mem_wdata;
   logic [3:0]  s_word_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   instr_encoder_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
      .alu_op(alu_op), .rn(rn), .rd(rd), .rm(rm), .shift_op(shift_op), .imm(imm),
      .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .busy(busy), .full(full), .err(err),
      .err_cnt(err_cnt), .word_cnt(word_cnt), .done(done)
   );

   instr_encoder_loader #(.ADDR_W(3), .BASE_ADDR(6)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(s_in_ready), .fmt(fmt), .opcode(opcode),
      .alu_op(alu_op), .rn(rn), .rd(rd), .rm(rm), .shift_op(shift_op), .imm(imm),
      .mem_write(s_mem_write), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
      .mem_ready(mem_ready), .busy(s_busy), .full(s_full), .err(s_err),
      .err_cnt(s_err_cnt), .word_cnt(s_word_cnt), .done(s_done)
   );

   typedef struct {
      logic [1:0]  fmt;
      logic [2:0]  opcode;
      logic [1:0]  alu_op;
      logic [2:0]  rn, rd, rm;
      logic [1:0]  shift_op;
      logic [15:0] imm;
      logic        exp_err;
      logic [15:0] exp_word;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_bundle(input vec_t v);
      fmt = v.fmt; opcode = v.opcode; alu_op = v.alu_op;
      rn = v.rn; rd = v.rd; rm = v.rm; shift_op = v.shift_op; imm = v.imm;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   logic [7:0] exp_addr;
   logic [8:0] exp_wcnt;
   logic [7:0] exp_ecnt;

   initial begin
      //             fmt    op      alu    rn    rd    rm    sh     imm       err   word
      vecs[0]  = '{2'b00, 3'b101, 2'b00, 3'd1, 3'd2, 3'd3, 2'b01, 16'd0,    1'b0, 16'hA14B};
      vecs[1]  = '{2'b01, 3'b110, 2'b10, 3'd3, 3'd0, 3'd0, 2'b00, -16'sd5,  1'b0, 16'hD3FB};
      vecs[2]  = '{2'b10, 3'b011, 2'b00, 3'd2, 3'd5, 3'd0, 2'b00, -16'sd1,  1'b0, 16'h62BF};
      vecs[3]  = '{2'b01, 3'b000, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 16'd200,  1'b1, 16'h0000};
      vecs[4]  = '{2'b10, 3'b000, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00, -16'sd17, 1'b1, 16'h0000};
      vecs[5]  = '{2'b10, 3'b000, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 16'd15,   1'b0, 16'h000F};
      vecs[6]  = '{2'b01, 3'b001, 2'b01, 3'd7, 3'd0, 3'd0, 2'b00, -16'sd128,1'b0, 16'h2F80};
      vecs[7]  = '{2'b01, 3'b000, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 16'd127,  1'b0, 16'h007F};
      vecs[8]  = '{2'b11, 3'b111, 2'b11, 3'd7, 3'd7, 3'd7, 2'b11, 16'hFFFF, 1'b0, 16'hF800};
      vecs[9]  = '{2'b01, 3'b000, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00, -16'sd129,1'b1, 16'h0000};
      vecs[10] = '{2'b10, 3'b010, 2'b01, 3'd1, 3'd3, 3'd0, 2'b00, -16'sd16, 1'b0, 16'h4970};
      vecs[11] = '{2'b10, 3'b000, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 16'd16,   1'b1, 16'h0000};
      vecs[12] = '{2'b00, 3'b000, 2'b11, 3'd4, 3'd6, 3'd5, 2'b10, 16'd0,    1'b0, 16'h1CD5};

      rst_n = 1'b0; start = 0; finish = 0; in_valid = 0; mem_ready = 1;
      fmt = 0; opcode = 0; alu_op = 0; rn = 0; rd = 0; rm = 0; shift_op = 0; imm = 0;
      #12;
      chk("rst_mem_addr", mem_addr, 8'd0);
      chk("rst_s_mem_addr", s_mem_addr, 3'd6);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_word_cnt", word_cnt, 0);
      chk("rst_err_cnt", err_cnt, 0);
      rst_n = 1'b1;
      step();

      // bundles ignored in IDLE
      drive_bundle(vecs[0]);
      chk("idle_mem_write", mem_write, 0);
      chk("idle_busy", busy, 0);

      // full address space on the small instance
      pulse_start();
      chk("start_busy", busy, 1);
      chk("start_in_ready", in_ready, 1);
      drive_bundle(vecs[0]);
      chk("s_wr0_write", s_mem_write, 1);
      chk("s_wr0_addr", s_mem_addr, 3'd6);
      step();
      drive_bundle(vecs[1]);
      chk("s_wr1_write", s_mem_write, 1);
      chk("s_wr1_addr", s_mem_addr, 3'd7);
      step();
      chk("s_full", s_full, 1);
      chk("s_full_in_ready", s_in_ready, 0);
      chk("s_full_addr", s_mem_addr, 3'd7);
      chk("s_full_word_cnt", s_word_cnt, 4'd2);
      finish = 1'b1;
      step();
      finish = 1'b0;
      chk("s_done", s_done, 1);
      chk("s_busy_after_finish", s_busy, 0);
      chk("s_full_cleared", s_full, 0);
      chk("done", done, 1);
      step();
      chk("done_pulse_end", done, 0);

      // table-driven encode / range check
      pulse_start();
      exp_addr = 0; exp_wcnt = 0; exp_ecnt = 0;
      for (int i = 0; i < 13; i++) begin
         chk($sformatf("v%0d_in_ready", i), in_ready, 1);
         drive_bundle(vecs[i]);
         if (vecs[i].exp_err) begin
            exp_ecnt++;
            chk($sformatf("v%0d_err", i), err, 1);
            chk($sformatf("v%0d_err_cnt", i), err_cnt, exp_ecnt);
            chk($sformatf("v%0d_no_write", i), mem_write, 0);
         end else begin
            chk($sformatf("v%0d_write", i), mem_write, 1);
            chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].exp_word);
            chk($sformatf("v%0d_addr", i), mem_addr, exp_addr);
            chk($sformatf("v%0d_err_low", i), err, 0);
            chk($sformatf("v%0d_ready_low", i), in_ready, 0);
            step();
            exp_wcnt++;
            exp_addr++;
            chk($sformatf("v%0d_word_cnt", i), word_cnt, exp_wcnt);
            chk($sformatf("v%0d_ready_again", i), in_ready, 1);
         end
      end

      // backpressure: four cycles of mem_ready=0
      mem_ready = 1'b0;
      drive_bundle(vecs[0]);
      for (int c = 0; c < 4; c++) begin
         chk("bp_write", mem_write, 1);
         chk("bp_addr", mem_addr, exp_addr);
         chk("bp_wdata", mem_wdata, 16'hA14B);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_word_cnt", word_cnt, exp_wcnt);
         step();
      end
      mem_ready = 1'b1;
      chk("bp_still_write", mem_write, 1);
      step();
      exp_wcnt++; exp_addr++;
      chk("bp_done_write", mem_write, 0);
      chk("bp_word_cnt_inc", word_cnt, exp_wcnt);
      chk("bp_addr_inc", mem_addr, exp_addr);

      // finish together with an accept: accept wins, finish dropped
      finish = 1'b1;
      drive_bundle(vecs[2]);
      finish = 1'b0;
      chk("fa_write", mem_write, 1);
      chk("fa_no_done", done, 0);
      step();
      chk("fa_busy", busy, 1);
      chk("fa_in_ready", in_ready, 1);
      chk("fa_no_done2", done, 0);

      // start inside ACCEPT restarts the session
      pulse_start();
      chk("rs_addr", mem_addr, 8'd0);
      chk("rs_word_cnt", word_cnt, 0);
      chk("rs_err_cnt", err_cnt, 0);
      chk("rs_no_done", done, 0);
      chk("rs_busy", busy, 1);

      // plain finish
      finish = 1'b1;
      step();
      finish = 1'b0;
      chk("fin_done", done, 1);
      chk("fin_busy", busy, 0);

      // async reset in the middle of a stalled write
      pulse_start();
      mem_ready = 1'b0;
      drive_bundle(vecs[1]);
      chk("rw_write", mem_write, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rw_write_dropped", mem_write, 0);
      chk("rw_busy", busy, 0);
      chk("rw_in_ready", in_ready, 0);
      step();
      rst_n = 1'b1;
      mem_ready = 1'b1;
      step();
      chk("rw_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
